// File: rtl/packet_switch_seg_mask.sv
// AXI-Stream segment-count to byte-mask stage with length tracking,
// oversize truncation, a 2-entry output skid buffer and saturating stats.
module packet_switch_seg_mask #(
    parameter int DATA_BYTES    = 64,
    parameter int BV_W          = $clog2(DATA_BYTES) + 1,
    parameter int TUSER_W       = 8,
    parameter int MAX_PKT_BYTES = 9216,
    parameter int LEN_W         = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic [DATA_BYTES*8-1:0] s_tdata,
    input  logic [BV_W-1:0]         s_bytesvld,
    input  logic                    s_tlast,
    input  logic [TUSER_W-1:0]      s_tuser,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [DATA_BYTES*8-1:0] m_tdata,
    output logic [DATA_BYTES-1:0]   m_tkeep,
    output logic [BV_W-1:0]         m_bytesvld,
    output logic                    m_tlast,
    output logic [TUSER_W-1:0]      m_tuser,
    output logic                    m_trunc,
    output logic [LEN_W-1:0]        m_pkt_len,
    output logic [31:0]             pkt_cnt,
    output logic [31:0]             trunc_cnt,
    output logic [31:0]             fmt_err_cnt
);

    localparam int DW = DATA_BYTES * 8;
    localparam logic [BV_W-1:0] FULL = BV_W'(DATA_BYTES);
    localparam logic [LEN_W:0] MAXL = (LEN_W+1)'(MAX_PKT_BYTES);

    typedef enum logic {
        IN_PKT,
        DISCARD
    } state_e;

    typedef struct packed {
        logic [DW-1:0]         data;
        logic [DATA_BYTES-1:0] keep;
        logic [BV_W-1:0]       bv;
        logic                  last;
        logic [TUSER_W-1:0]    user;
        logic                  trunc;
        logic [LEN_W-1:0]      len;
    } beat_t;

    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input logic        en
    );
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    state_e          state_q, state_d;
    logic [LEN_W-1:0] len_acc_q, len_acc_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            wr_ptr_q, rd_ptr_q;
    logic            s_tready_q, m_tvalid_q;
    beat_t           ent_q [2];
    logic [31:0]     pkt_cnt_q, trunc_cnt_q, fmt_cnt_q;

    logic                  in_fire, push, pop;
    logic [BV_W-1:0]       n_raw, n_norm, n_emit;
    logic                  short_mid, cut;
    logic [LEN_W:0]        sum, room;
    logic [DATA_BYTES-1:0] keep;
    logic [DW-1:0]         data_m;
    beat_t                 beat_d;

    assign in_fire = s_tvalid & s_tready_q;
    assign push    = in_fire & (state_q == IN_PKT);
    assign pop     = m_tvalid_q & m_tready;

    // A short count on a middle beat is a framing error; treat it as full.
    assign n_raw     = ((s_bytesvld == '0) || (s_bytesvld > FULL)) ? FULL : s_bytesvld;
    assign short_mid = !s_tlast && (n_raw < FULL);
    assign n_norm    = short_mid ? FULL : n_raw;

    assign sum  = {1'b0, len_acc_q} + (LEN_W+1)'(n_norm);
    assign room = MAXL - {1'b0, len_acc_q};
    // Reaching the limit exactly is only legal if this beat ends the packet.
    assign cut  = s_tlast ? (sum > MAXL) : (sum >= MAXL);

    assign n_emit = cut ? BV_W'(room) : n_norm;
    assign keep   = ~({DATA_BYTES{1'b1}} >> n_emit);

    for (genvar b = 0; b < DATA_BYTES; b++) begin : g_mask
        assign data_m[b*8 +: 8] = keep[b] ? s_tdata[b*8 +: 8] : 8'h00;
    end

    always_comb begin
        beat_d       = '0;
        beat_d.data  = data_m;
        beat_d.keep  = keep;
        beat_d.bv    = n_emit;
        beat_d.last  = s_tlast | cut;
        beat_d.user  = s_tuser;
        beat_d.trunc = cut;
        beat_d.len   = cut ? LEN_W'(MAXL) : LEN_W'(sum);
    end

    always_comb begin
        state_d   = state_q;
        len_acc_d = len_acc_q;
        if (in_fire) begin
            unique case (state_q)
                IN_PKT: begin
                    len_acc_d = beat_d.last ? '0 : LEN_W'(sum);
                    if (cut && !s_tlast) begin
                        state_d = DISCARD;
                    end
                end
                DISCARD: begin
                    len_acc_d = '0;
                    if (s_tlast) begin
                        state_d = IN_PKT;
                    end
                end
                default: begin
                    state_d   = IN_PKT;
                    len_acc_d = '0;
                end
            endcase
        end
    end

    assign cnt_d = cnt_q + 2'(push) - 2'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IN_PKT;
            len_acc_q   <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            s_tready_q  <= 1'b0;
            m_tvalid_q  <= 1'b0;
            ent_q[0]    <= '0;
            ent_q[1]    <= '0;
            pkt_cnt_q   <= '0;
            trunc_cnt_q <= '0;
            fmt_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            len_acc_q  <= len_acc_d;
            cnt_q      <= cnt_d;
            s_tready_q <= (cnt_d < 2'd2);
            m_tvalid_q <= (cnt_d != 2'd0);
            if (push) begin
                ent_q[wr_ptr_q] <= beat_d;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            pkt_cnt_q   <= sat_inc(pkt_cnt_q, push & beat_d.last);
            trunc_cnt_q <= sat_inc(trunc_cnt_q, push & cut);
            fmt_cnt_q   <= sat_inc(fmt_cnt_q, push & short_mid);
        end
    end

    assign s_tready    = s_tready_q;
    assign m_tvalid    = m_tvalid_q;
    assign m_tdata     = ent_q[rd_ptr_q].data;
    assign m_tkeep     = ent_q[rd_ptr_q].keep;
    assign m_bytesvld  = ent_q[rd_ptr_q].bv;
    assign m_tlast     = ent_q[rd_ptr_q].last;
    assign m_tuser     = ent_q[rd_ptr_q].user;
    assign m_trunc     = ent_q[rd_ptr_q].trunc;
    assign m_pkt_len   = ent_q[rd_ptr_q].len;
    assign pkt_cnt     = pkt_cnt_q;
    assign trunc_cnt   = trunc_cnt_q;
    assign fmt_err_cnt = fmt_cnt_q;

endmodule

// File: tb/tb_packet_switch_seg_mask.sv
// Directed bench for packet_switch_seg_mask: packet-level reference model
// checked every output cycle, plus literal expectations per scenario.
module tb_packet_switch_seg_mask;

    localparam int DB   = 64;
    localparam int BVW  = 7;
    localparam int TW   = 8;
    localparam int MAXB = 9216;
    localparam int LW   = 14;
    localparam int DW   = DB * 8;

    logic           clk;
    logic           rst_n;
    logic           s_tvalid;
    logic           s_tready;
    logic [DW-1:0]  s_tdata;
    logic [BVW-1:0] s_bytesvld;
    logic           s_tlast;
    logic [TW-1:0]  s_tuser;
    logic           m_tvalid;
    logic           m_tready;
    logic [DW-1:0]  m_tdata;
    logic [DB-1:0]  m_tkeep;
    logic [BVW-1:0] m_bytesvld;
    logic           m_tlast;
    logic [TW-1:0]  m_tuser;
    logic           m_trunc;
    logic [LW-1:0]  m_pkt_len;
    logic [31:0]    pkt_cnt;
    logic [31:0]    trunc_cnt;
    logic [31:0]    fmt_err_cnt;

    packet_switch_seg_mask #(
        .DATA_BYTES   (DB),
        .BV_W         (BVW),
        .TUSER_W      (TW),
        .MAX_PKT_BYTES(MAXB),
        .LEN_W        (LW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tdata    (s_tdata),
        .s_bytesvld (s_bytesvld),
        .s_tlast    (s_tlast),
        .s_tuser    (s_tuser),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .m_tkeep    (m_tkeep),
        .m_bytesvld (m_bytesvld),
        .m_tlast    (m_tlast),
        .m_tuser    (m_tuser),
        .m_trunc    (m_trunc),
        .m_pkt_len  (m_pkt_len),
        .pkt_cnt    (pkt_cnt),
        .trunc_cnt  (trunc_cnt),
        .fmt_err_cnt(fmt_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [DB-1:0] keep;
        int            bv;
        bit            last;
        logic [TW-1:0] user;
        bit            trunc;
        int            len;
    } beat_t;

    int    total = 0;
    int    bad   = 0;
    beat_t expq[$];
    beat_t obs[$];

    int acc = 0;
    bit drop = 0;
    int mpkt = 0;
    int mtrunc = 0;
    int mfmt = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s", nm);
    endtask

    // Reference: a packet may hold at most MAXB bytes; whatever would push
    // it past that (or reach it with more to come) is cut there.
    task automatic model_accept(input int bv, input bit last,
                                input logic [DW-1:0] d, input logic [TW-1:0] u);
        beat_t e;
        int n;
        int room;
        n = (bv == 0 || bv > DB) ? DB : bv;
        if (drop) begin
            if (last) drop = 0;
            return;
        end
        if (!last && n < DB) begin
            mfmt++;
            n = DB;
        end
        room = MAXB - acc;
        e.trunc = (acc + n > MAXB) || (!last && acc + n == MAXB);
        e.bv = e.trunc ? room : n;
        e.last = last || e.trunc;
        e.user = u;
        e.len = acc + e.bv;
        e.keep = '0;
        e.data = '0;
        for (int i = 0; i < DB; i++) begin
            if (i < e.bv) begin
                e.keep[DB-1-i] = 1'b1;
                e.data[(DB-1-i)*8 +: 8] = d[(DB-1-i)*8 +: 8];
            end
        end
        if (e.trunc && !last) drop = 1;
        acc = e.last ? 0 : e.len;
        if (e.last) mpkt++;
        if (e.trunc) mtrunc++;
        expq.push_back(e);
    endtask

    task automatic model_reset();
        expq.delete();
        acc = 0;
        drop = 0;
        mpkt = 0;
        mtrunc = 0;
        mfmt = 0;
    endtask

    always @(negedge clk) begin : cmp
        beat_t e;
        beat_t o;
        if (rst_n && m_tvalid) begin
            if (expq.size() == 0) begin
                fail_now("unexpected_beat");
            end else begin
                e = expq[0];
                chk("tdata", m_tdata, e.data);
                chk("tkeep", m_tkeep, e.keep);
                chk("bytesvld", m_bytesvld, e.bv);
                chk("tlast", m_tlast, e.last);
                chk("tuser", m_tuser, e.user);
                chk("trunc", m_trunc, e.trunc);
                chk("pkt_len", m_pkt_len, e.len);
                if (m_tready) begin
                    void'(expq.pop_front());
                    o.data = m_tdata;
                    o.keep = m_tkeep;
                    o.bv = int'(m_bytesvld);
                    o.last = m_tlast;
                    o.user = m_tuser;
                    o.trunc = m_trunc;
                    o.len = int'(m_pkt_len);
                    obs.push_back(o);
                end
            end
        end
    end

    function automatic beat_t at(input int i);
        beat_t z;
        z = '{default: '0};
        if (i < obs.size()) return obs[i];
        return z;
    endfunction

    task automatic send(input int bv, input bit last, input logic [TW-1:0] u);
        logic [DW-1:0] d;
        int waits;
        for (int w = 0; w < DB / 4; w++) d[w*32 +: 32] = $urandom;
        s_tvalid = 1'b1;
        s_tdata = d;
        s_bytesvld = BVW'(bv);
        s_tlast = last;
        s_tuser = u;
        waits = 0;
        @(negedge clk);
        while (!s_tready) begin
            waits++;
            if (waits > 200) begin
                fail_now("s_tready_timeout");
                s_tvalid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        model_accept(bv, last, d, u);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int waits;
        waits = 0;
        while (expq.size() != 0 && waits < 300) begin
            @(negedge clk);
            waits++;
        end
        if (expq.size() != 0) fail_now("drain_timeout");
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_counters(input int p, input int t, input int f);
        chk("pkt_cnt", pkt_cnt, p);
        chk("trunc_cnt", trunc_cnt, t);
        chk("fmt_err_cnt", fmt_err_cnt, f);
        chk("pkt_cnt_model", pkt_cnt, mpkt);
        chk("trunc_cnt_model", trunc_cnt, mtrunc);
        chk("fmt_cnt_model", fmt_err_cnt, mfmt);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_tkeep", m_tkeep, 0);
        chk("rst_m_bytesvld", m_bytesvld, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_m_tuser", m_tuser, 0);
        chk("rst_m_trunc", m_trunc, 0);
        chk("rst_m_pkt_len", m_pkt_len, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_trunc_cnt", trunc_cnt, 0);
        chk("rst_fmt_cnt", fmt_err_cnt, 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog_expired");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $finish;
    end

    initial begin : main
        int b;
        logic [DB-1:0] k;
        logic [DB-1:0] ones;
        bit tr[4];
        rst_n = 1'b0;
        s_tvalid = 1'b0;
        s_tdata = '0;
        s_bytesvld = '0;
        s_tlast = 1'b0;
        s_tuser = '0;
        m_tready = 1'b1;
        ones = '1;

        repeat (2) @(negedge clk);
        chk_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("s_tready_before_edge", s_tready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("s_tready_after_edge", s_tready, 1);
        @(posedge clk);
        #1;

        // single short last beat
        b = obs.size();
        send(5, 1, 8'h11);
        drain();
        k = {5'h1F, 59'b0};
        chk("t1_keep", at(b).keep, k);
        chk("t1_low_bytes", at(b).data[59*8-1:0], 0);
        chk("t1_bv", at(b).bv, 5);
        chk("t1_len", at(b).len, 5);
        chk_counters(1, 0, 0);

        // zero and oversize counts mean full
        b = obs.size();
        send(0, 1, 8'h21);
        send(65, 1, 8'h22);
        drain();
        chk("t2_bv0", at(b).bv, 64);
        chk("t2_keep0", at(b).keep, ones);
        chk("t2_bv1", at(b+1).bv, 64);
        chk("t2_keep1", at(b+1).keep, ones);
        chk_counters(3, 0, 0);

        // short middle beat is a format error
        b = obs.size();
        send(10, 0, 8'h31);
        send(64, 0, 8'h32);
        send(7, 1, 8'h33);
        drain();
        chk("t3_bv_first", at(b).bv, 64);
        chk("t3_len_mid", at(b+1).len, 128);
        chk("t3_len_last", at(b+2).len, 135);
        k = {7'h7F, 57'b0};
        chk("t3_keep_last", at(b+2).keep, k);
        chk_counters(4, 0, 1);

        // oversize packet truncated at MAXB
        b = obs.size();
        for (int i = 0; i < 145; i++) send(64, (i == 144), 8'h40);
        drain();
        chk("t4_beats_out", obs.size() - b, 144);
        chk("t4_pre_last", at(b+142).last, 0);
        chk("t4_last", at(b+143).last, 1);
        chk("t4_trunc", at(b+143).trunc, 1);
        chk("t4_len", at(b+143).len, 9216);
        chk_counters(5, 1, 1);
        b = obs.size();
        send(20, 1, 8'h41);
        drain();
        chk("t4_next_len", at(b).len, 20);
        chk("t4_next_trunc", at(b).trunc, 0);
        chk_counters(6, 1, 1);

        // output stall during continuous input
        b = obs.size();
        fork
            begin
                for (int i = 0; i < 6; i++) send(8 * (i + 1), 1, 8'(8'h50 + i));
            end
            begin
                m_tready = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    tr[c] = s_tready;
                end
                @(posedge clk);
                #1;
                m_tready = 1'b1;
            end
        join
        drain();
        chk("t5_rdy0", tr[0], 1);
        chk("t5_rdy1", tr[1], 1);
        chk("t5_rdy2", tr[2], 0);
        chk("t5_rdy3", tr[3], 0);
        chk("t5_beats_out", obs.size() - b, 6);
        for (int i = 0; i < 6; i++) chk("t5_order", at(b+i).bv, 8 * (i + 1));
        chk_counters(12, 1, 1);

        // reset mid-packet
        send(64, 0, 8'h61);
        send(64, 0, 8'h62);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        b = obs.size();
        send(20, 1, 8'h70);
        drain();
        chk("t6_beats_out", obs.size() - b, 1);
        chk("t6_len", at(b).len, 20);
        chk("t6_trunc", at(b).trunc, 0);
        chk("t6_bv", at(b).bv, 20);
        chk_counters(1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
